ov7670_config_sequencer: RTL
============================

// Module: ov7670_config_sequencer
// PURPOSE
//   Boot-time register loader for the OV7670 camera. Walks a register ROM of {addr,data} pairs
//   and feeds each one to SCCB_interface through its start/address/data/ready handshake.
//   Sits between top-level control (start button, status LED) and SCCB_interface. Supports
//   in-ROM delay markers (needed after the 0x12=0x80 soft reset) and reports busy/done.
// PARAMETERS
//   CLK_FREQ        25000000  system clock in Hz; used for the delay timebase
//   ROM_DEPTH       128       number of 16-bit ROM entries; index width = $clog2(ROM_DEPTH)
//   DELAY_MS        10        length of one delay marker, in ms
//   TIMEOUT_CYCLES  100000    SCCB handshake watchdog limit (used only with the macro below)
// PORTS
//   clk_12MHz    in   1  system clock; all logic on the rising edge
//   rst          in   1  asynchronous, active-high reset
//   start        in   1  level; sampled in IDLE/DONE/ERROR; begins a load from index 0
//   sccb_ready   in   1  SCCB_interface ready: 1 = idle, 0 = transfer in progress
//   sccb_start   out  1  one-cycle pulse that launches one SCCB write
//   sccb_addr    out  8  register address; held stable from the pulse until ready returns high
//   sccb_data    out  8  register data; same stability rule as sccb_addr
//   busy         out  1  1 in any state except IDLE/DONE/ERROR
//   done         out  1  sticky 1 after the end of the ROM; cleared by start or rst
//   error        out  1  sticky watchdog flag (only with the macro; otherwise tied 0)
//   cfg_index    out  log2(ROM_DEPTH)  current ROM index, for debug
// BEHAVIOUR
//   Reset: state=IDLE, index=0. sccb_start, sccb_addr, sccb_data, busy, done, error and
//     cfg_index are all 0. Asserting rst mid-transfer drops sccb_start at once; the SCCB block
//     must be reset by the same rst.
//   FSM states: IDLE, FETCH, DECODE, ISSUE, WAIT_ACK, WAIT_DONE, DELAY, DONE, ERROR.
//   IDLE/DONE/ERROR + start=1 -> FETCH. On this transition index=0 and done/error are cleared.
//   start while busy is ignored.
//   FETCH: ROM read is synchronous, 1-cycle latency -> DECODE.
//   DECODE entry handling:
//     16'hFFFF = end marker -> DONE.
//     16'hFFF0 = delay marker -> DELAY.
//     any other value -> latch addr=entry[15:8], data=entry[7:0] -> ISSUE.
//   ISSUE: waits for sccb_ready=1, then sccb_start=1 for exactly one cycle -> WAIT_ACK.
//   WAIT_ACK: waits for sccb_ready=0. WAIT_DONE: waits for sccb_ready=1.
//     Then index++ -> FETCH.
//   DELAY: counts (CLK_FREQ/1000)*DELAY_MS cycles, then index++ -> FETCH.
//   Index wrap: if index reaches ROM_DEPTH-1 without an end marker, DONE follows that entry.
//     The index never wraps to 0 mid-load.
//   Minimum write-to-write spacing is FETCH+DECODE+ISSUE, i.e. 3 cycles plus the SCCB time.
// CONFIGURATION
//   OV7670_SCCB_TIMEOUT_EN defined:
//     a watchdog counts cycles in WAIT_ACK+WAIT_DONE.
//     Reaching TIMEOUT_CYCLES -> ERROR: error=1, busy=0, sccb_start=0, index frozen.
//   Not defined: no watchdog; the FSM waits indefinitely; error is tied 0; ERROR unreachable.
// STRUCTURE
//   Package ov7670_pkg holds:
//     the FSM state enum;
//     ROM_END=16'hFFFF and ROM_DELAY=16'hFFF0;
//     the ov7670_reg_t struct {addr[7:0], data[7:0]}.
//   Sub-module ov7670_config_rom: synchronous ROM with inputs clk and index, output 16-bit
//     entry. Initial contents come from a $readmemh file, so register tables can change
//     without touching the FSM.
// TESTING (the SCCB slave is a model whose ready drops 2 cycles after start and returns 50
//   cycles later)
//   ROM {1280, FFF0, 1101, FFFF}, DELAY_MS scaled to 100 cycles, start pulse ->
//     writes 12/80, then >=100 idle cycles, then 11/01. done=1 and busy=0 after the 2nd
//     write; exactly 2 sccb_start pulses.
//   Model holds ready=0 for 500 cycles -> sccb_addr/sccb_data stay stable and there is no
//     second pulse until ready rises.
//   start held high throughout a load -> no restart. start re-asserted after done ->
//     done clears and the load replays from index 0.
//   rst asserted in WAIT_DONE -> all outputs 0 asynchronously, state=IDLE. A later start
//     reloads from index 0.
//   ROM with no end marker, ROM_DEPTH=4 -> exactly 4 writes, then done=1, cfg_index=3.
//   With OV7670_SCCB_TIMEOUT_EN and TIMEOUT_CYCLES=200, ready stuck low ->
//     error=1 at cycle 200; start clears it and retries.

Source files
------------

// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared types and constants for the OV7670 boot-time register loader.
// Holds the sequencer state encoding, the ROM control markers and the {addr,data} entry layout.
package ov7670_pkg;

    // Sequencer states. IDLE/DONE/ERROR are the resting states in which start is honoured.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_ISSUE     = 4'd3,
        ST_WAIT_ACK  = 4'd4,
        ST_WAIT_DONE = 4'd5,
        ST_DELAY     = 4'd6,
        ST_DONE      = 4'd7,
        ST_ERROR     = 4'd8
    } cfg_state_t;

    // ROM control markers; neither can be a real write because 0xFF is not a register address.
    localparam logic [15:0] ROM_END   = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY = 16'hFFF0;

    // One ROM entry: register address in the upper byte, register value in the lower byte.
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } ov7670_reg_t;

    // True in the states where the loader is not busy and start may launch a new load.
    function automatic logic is_rest_state(input cfg_state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/ov7670_config_rom.sv
// ov7670_config_rom: synchronous register-table ROM, one-cycle read latency.
// Contents come from the ROM_INIT parameter (entry i at bits [16*i +: 16]), so a different
// register table is a parameter override at instantiation and never an edit to the FSM.
// Unused entries default to the end marker.
module ov7670_config_rom
    import ov7670_pkg::*;
#(
    parameter int                        ROM_DEPTH = 128,
    parameter int                        IDX_W     = $clog2(ROM_DEPTH),
    parameter logic [ROM_DEPTH*16-1:0]   ROM_INIT  = {ROM_DEPTH{ROM_END}}
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] index,
    output logic [15:0]      entry
);

    logic [15:0] r_entry;

    // Registered table read: the entry for index appears one cycle after index is presented.
    // NOTE: the ROM output register has no reset; the sequencer only looks at it in DECODE,
    // which always follows a FETCH cycle that has loaded it.
    always_ff @(posedge clk) begin
        r_entry <= ROM_INIT[{index, 4'b0000} +: 16];
    end

    assign entry = r_entry;

endmodule

// File: rtl/ov7670_config_sequencer.sv
// ov7670_config_sequencer: walks the register ROM and feeds each {addr,data} pair to
// SCCB_interface through its start/ready handshake, honouring in-ROM delay markers
// (needed after the 0x12=0x80 soft reset) and reporting busy/done.
// Optional build macro OV7670_SCCB_TIMEOUT_EN adds a handshake watchdog that parks the
// loader in ERROR after TIMEOUT_CYCLES; without it error is tied 0 and ERROR is unreachable.
module ov7670_config_sequencer
    import ov7670_pkg::*;
#(
    parameter int                        CLK_FREQ       = 25000000,
    parameter int                        ROM_DEPTH      = 128,
    parameter int                        DELAY_MS       = 10,
    parameter int                        TIMEOUT_CYCLES = 100000,
    parameter logic [ROM_DEPTH*16-1:0]   ROM_INIT       = {ROM_DEPTH{ROM_END}}
) (
    input  logic                         clk_12MHz,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         sccb_ready,
    output logic                         sccb_start,
    output logic [7:0]                   sccb_addr,
    output logic [7:0]                   sccb_data,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [$clog2(ROM_DEPTH)-1:0] cfg_index
);

    localparam int               IDX_W        = $clog2(ROM_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(ROM_DEPTH - 1);
    localparam int               DELAY_CYCLES = (CLK_FREQ / 1000) * DELAY_MS;
    localparam int               DLY_W        = $clog2(DELAY_CYCLES + 1);
    localparam logic [DLY_W-1:0] DLY_LAST     = DLY_W'(DELAY_CYCLES - 1);

    cfg_state_t       r_state;
    logic [IDX_W-1:0] r_index;
    ov7670_reg_t      r_reg;
    logic             r_sccb_start;
    logic             r_done;
    logic [DLY_W-1:0] r_dly;
    logic [15:0]      w_entry;

`ifdef OV7670_SCCB_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_wd;
    logic            r_error;

    // Watchdog: counts every cycle spent waiting on SCCB_interface, restarts per write.
    always_ff @(posedge clk_12MHz or posedge rst) begin
        if (rst) begin
            r_wd <= '0;
        end else if (r_state == ST_WAIT_ACK || r_state == ST_WAIT_DONE) begin
            r_wd <= r_wd + 1'b1;
        end else begin
            r_wd <= '0;
        end
    end
`endif

    ov7670_config_rom #(
        .ROM_DEPTH (ROM_DEPTH),
        .IDX_W     (IDX_W),
        .ROM_INIT  (ROM_INIT)
    ) u_rom (
        .clk   (clk_12MHz),
        .index (r_index),
        .entry (w_entry)
    );

    // Main sequencer: fetch/decode each entry, run the SCCB handshake or a delay, then advance.
    // NOTE: all state here is assigned with <= so every branch reads the pre-edge values and
    // the order of statements inside the block cannot change the result.
    always_ff @(posedge clk_12MHz or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_index      <= '0;
            r_reg        <= '0;
            r_sccb_start <= 1'b0;
            r_done       <= 1'b0;
            r_dly        <= '0;
`ifdef OV7670_SCCB_TIMEOUT_EN
            r_error      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        r_state <= ST_FETCH;
                        r_index <= '0;
                        r_done  <= 1'b0;
`ifdef OV7670_SCCB_TIMEOUT_EN
                        r_error <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_entry == ROM_END) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (w_entry == ROM_DELAY) begin
                        r_dly   <= '0;
                        r_state <= ST_DELAY;
                    end else begin
                        r_reg   <= ov7670_reg_t'(w_entry);
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (sccb_ready) begin
                        r_sccb_start <= 1'b1;
                        r_state      <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    r_sccb_start <= 1'b0;
                    if (!sccb_ready) begin
                        r_state <= ST_WAIT_DONE;
                    end
`ifdef OV7670_SCCB_TIMEOUT_EN
                    else if (r_wd == WD_LAST) begin
                        r_state <= ST_ERROR;
                        r_error <= 1'b1;
                    end
`endif
                end
                ST_WAIT_DONE: begin
                    if (sccb_ready) begin
                        if (r_index == LAST_IDX) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
`ifdef OV7670_SCCB_TIMEOUT_EN
                    else if (r_wd == WD_LAST) begin
                        r_state <= ST_ERROR;
                        r_error <= 1'b1;
                    end
`endif
                end
                ST_DELAY: begin
                    if (r_dly == DLY_LAST) begin
                        if (r_index == LAST_IDX) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end else begin
                        r_dly <= r_dly + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sccb_start = r_sccb_start;
    assign sccb_addr  = r_reg.addr;
    assign sccb_data  = r_reg.data;
    assign busy       = !is_rest_state(r_state);
    assign done       = r_done;
    assign cfg_index  = r_index;
`ifdef OV7670_SCCB_TIMEOUT_EN
    assign error      = r_error;
`else
    assign error      = 1'b0;
`endif

endmodule
